// File: rtl/gpio_pattern_pkg.sv
// Shared encodings and seed values for the GPIO pattern generator.
package gpio_pattern_pkg;

    typedef enum logic [1:0] {
        MODE_ROT_W0 = 2'd0,
        MODE_ROT_W1 = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_LFSR   = 2'd3
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    // Seed for a given mode, right-aligned in 64 bits; callers truncate to their width.
    function automatic logic [63:0] seed_of(input mode_e mode, input int unsigned width);
        logic [63:0] mask;
        mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        seed_of = (mode == MODE_ROT_W0) ? (mask & ~64'd1) : 64'd1;
    endfunction

endpackage

// File: rtl/pattern_prescaler.sv
// Step-rate divider: emits a tick every div+1 active cycles, cleared by restart.
module pattern_prescaler #(
    parameter int unsigned DIV_W = 24
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_enable,
    input  logic             i_running,
    input  logic             i_restart,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_tick
);

    logic [DIV_W-1:0] r_cnt;
    logic             w_active;
    logic             w_match;

    // Counting stops the moment enable drops, so a pause never loses or gains a cycle.
    assign w_active = i_enable && i_running;
    assign w_match  = (r_cnt == i_div);
    assign o_tick   = w_active && w_match && !i_restart;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (i_restart) begin
            r_cnt <= '0;
        end else if (w_active) begin
            r_cnt <= w_match ? '0 : r_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/gpio_pattern_gen.sv
// Selectable GPIO pattern generator (rotate-zero, rotate-one, bounce, LFSR) with
// run/pause, restart, step/wrap strobes and a wrap counter.
module gpio_pattern_gen
    import gpio_pattern_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned DIV_W     = 24,
    parameter logic [63:0] LFSR_TAPS = 64'h8020_0003,
    parameter int unsigned WRAP_W    = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              enable,
    input  logic              restart,
    input  logic [1:0]        mode,
    input  logic [DIV_W-1:0]  div,
    output logic [WIDTH-1:0]  pattern,
    output logic              step,
    output logic              wrap,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic              running
);

    localparam logic [WIDTH-1:0] ResetSeed = WIDTH'(seed_of(MODE_ROT_W0, WIDTH));
    localparam logic [WIDTH-1:0] Taps      = LFSR_TAPS[WIDTH-1:0];

    state_e            r_state;
    state_e            w_state_d;
    mode_e             r_mode;
    dir_e              r_dir;
    dir_e              w_next_dir;
    logic [WIDTH-1:0]  r_pattern;
    logic [WIDTH-1:0]  w_next;
    logic [WIDTH-1:0]  w_seed_new;
    logic [WIDTH-1:0]  w_seed_cur;
    logic              r_step;
    logic              r_wrap;
    logic [WRAP_W-1:0] r_wrap_cnt;
    logic              w_tick;
    logic              w_wrap;

    pattern_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk       (clk),
        .rstn      (rstn),
        .i_enable  (enable),
        .i_running (r_state == ST_RUN),
        .i_restart (restart),
        .i_div     (div),
        .o_tick    (w_tick)
    );

    assign w_seed_new = WIDTH'(seed_of(mode_e'(mode), WIDTH));
    assign w_seed_cur = WIDTH'(seed_of(r_mode, WIDTH));

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            ST_IDLE: if (enable)  w_state_d = ST_RUN;
            ST_RUN:  if (!enable) w_state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        w_next     = r_pattern;
        w_next_dir = r_dir;
        unique case (r_mode)
            MODE_ROT_W0, MODE_ROT_W1: begin
                w_next = {r_pattern[WIDTH-2:0], r_pattern[WIDTH-1]};
            end
            MODE_BOUNCE: begin
                // Direction flips on reaching an end, so the end value is shown only once.
                if (r_dir == DIR_LEFT) begin
                    w_next = {r_pattern[WIDTH-2:0], 1'b0};
                    if (w_next[WIDTH-1]) w_next_dir = DIR_RIGHT;
                end else begin
                    w_next = {1'b0, r_pattern[WIDTH-1:1]};
                    if (w_next[0]) w_next_dir = DIR_LEFT;
                end
            end
            MODE_LFSR: begin
                w_next = {1'b0, r_pattern[WIDTH-1:1]} ^ (r_pattern[0] ? Taps : '0);
            end
        endcase
    end

    assign w_wrap = (w_next == w_seed_cur) && (w_next_dir == DIR_LEFT);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= ST_IDLE;
            r_mode     <= MODE_ROT_W0;
            r_pattern  <= ResetSeed;
            r_dir      <= DIR_LEFT;
            r_step     <= 1'b0;
            r_wrap     <= 1'b0;
            r_wrap_cnt <= '0;
        end else begin
            r_state <= w_state_d;
            r_step  <= 1'b0;
            r_wrap  <= 1'b0;
            if (restart) begin
                r_mode     <= mode_e'(mode);
                r_pattern  <= w_seed_new;
                r_dir      <= DIR_LEFT;
                r_wrap_cnt <= '0;
            end else if (w_tick) begin
                r_pattern <= w_next;
                r_dir     <= w_next_dir;
                r_step    <= 1'b1;
                if (w_wrap) begin
                    r_wrap     <= 1'b1;
                    r_wrap_cnt <= r_wrap_cnt + WRAP_W'(1);
                end
            end
        end
    end

    assign pattern  = r_pattern;
    assign step     = r_step;
    assign wrap     = r_wrap;
    assign wrap_cnt = r_wrap_cnt;
    assign running  = (r_state == ST_RUN);

endmodule

// File: tb/tb_gpio_pattern_gen.sv
// Bench for gpio_pattern_gen: 8-bit and 4-bit instances share stimulus and are
// checked every cycle against a step-index reference model.
module tb_gpio_pattern_gen;

    logic        clk;
    logic        rstn;
    logic        enable;
    logic        restart;
    logic [1:0]  mode;
    logic [3:0]  div;

    logic [7:0]  pat8;
    logic        step8, wrap8, run8;
    logic [15:0] wcnt8;
    logic [3:0]  pat4;
    logic        step4, wrap4, run4;
    logic [15:0] wcnt4;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: run flag, prescale count, steps since restart, latched mode.
    bit m_run;
    int m_cnt;
    int m_k;
    int m_mode;
    bit m_step;

    logic [7:0] lfsr8 [0:254];
    logic [3:0] lfsr4 [0:14];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    gpio_pattern_gen #(
        .WIDTH     (8),
        .DIV_W     (4),
        .LFSR_TAPS (64'hB8),
        .WRAP_W    (16)
    ) u_dut8 (
        .clk      (clk),
        .rstn     (rstn),
        .enable   (enable),
        .restart  (restart),
        .mode     (mode),
        .div      (div),
        .pattern  (pat8),
        .step     (step8),
        .wrap     (wrap8),
        .wrap_cnt (wcnt8),
        .running  (run8)
    );

    gpio_pattern_gen #(
        .WIDTH     (4),
        .DIV_W     (4),
        .LFSR_TAPS (64'hC),
        .WRAP_W    (16)
    ) u_dut4 (
        .clk      (clk),
        .rstn     (rstn),
        .enable   (enable),
        .restart  (restart),
        .mode     (mode),
        .div      (div),
        .pattern  (pat4),
        .step     (step4),
        .wrap     (wrap4),
        .wrap_cnt (wcnt4),
        .running  (run4)
    );

    function automatic int period(input int w, input int md);
        case (md)
            0, 1:    return w;
            2:       return 2 * (w - 1);
            default: return (1 << w) - 1;
        endcase
    endfunction

    // Pattern after k steps from the seed of mode md.
    function automatic logic [63:0] exp_pat(input int w, input int md, input int k);
        logic [63:0] mask;
        int p;
        int b;
        mask = (64'd1 << w) - 64'd1;
        case (md)
            0: return mask ^ (64'd1 << (k % w));
            1: return 64'd1 << (k % w);
            2: begin
                p = k % (2 * (w - 1));
                b = (p < w) ? p : 2 * (w - 1) - p;
                return 64'd1 << b;
            end
            default: return (w == 8) ? 64'(lfsr8[k % 255]) : 64'(lfsr4[k % 15]);
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv)
        else begin
            n_bad++;
            $error("FAIL %s at %0t: observed %0h expected %0h", tag, $time, obs, expv);
        end
    endtask

    task automatic check_all();
        int p8;
        int p4;
        p8 = period(8, m_mode);
        p4 = period(4, m_mode);
        check("pattern8",  64'(pat8),  exp_pat(8, m_mode, m_k));
        check("step8",     64'(step8), 64'(m_step));
        check("wrap8",     64'(wrap8), 64'(m_step && (m_k % p8 == 0)));
        check("wrap_cnt8", 64'(wcnt8), 64'((m_k / p8) & 16'hFFFF));
        check("running8",  64'(run8),  64'(m_run));
        check("pattern4",  64'(pat4),  exp_pat(4, m_mode, m_k));
        check("step4",     64'(step4), 64'(m_step));
        check("wrap4",     64'(wrap4), 64'(m_step && (m_k % p4 == 0)));
        check("wrap_cnt4", 64'(wcnt4), 64'((m_k / p4) & 16'hFFFF));
        check("running4",  64'(run4),  64'(m_run));
    endtask

    task automatic model_reset();
        m_run  = 1'b0;
        m_cnt  = 0;
        m_k    = 0;
        m_mode = 0;
        m_step = 1'b0;
    endtask

    // One clock: advance the model with the inputs in force at the edge, then compare.
    task automatic cycle();
        bit en;
        bit rs;
        int dv;
        int md;
        bit active;
        en = enable;
        rs = restart;
        dv = int'(div);
        md = int'(mode);
        @(posedge clk);
        #1;
        active = m_run && en;
        m_step = 1'b0;
        if (rs) begin
            m_mode = md;
            m_k    = 0;
            m_cnt  = 0;
        end else if (active) begin
            if (m_cnt == dv) begin
                m_cnt  = 0;
                m_k    = m_k + 1;
                m_step = 1'b1;
            end else begin
                m_cnt = (m_cnt + 1) % 16;
            end
        end
        m_run = en;
        check_all();
    endtask

    task automatic do_restart(input logic [1:0] md);
        restart = 1'b1;
        mode    = md;
        cycle();
        restart = 1'b0;
    endtask

    initial begin
        logic [7:0] v8;
        logic [3:0] v4;
        int guard;

        v8 = 8'd1;
        for (int i = 0; i < 255; i++) begin
            lfsr8[i] = v8;
            v8 = (v8 >> 1) ^ (v8[0] ? 8'hB8 : 8'h00);
        end
        v4 = 4'd1;
        for (int i = 0; i < 15; i++) begin
            lfsr4[i] = v4;
            v4 = (v4 >> 1) ^ (v4[0] ? 4'hC : 4'h0);
        end

        rstn    = 1'b0;
        enable  = 1'b0;
        restart = 1'b0;
        mode    = 2'd0;
        div     = 4'd0;
        model_reset();
        #12;
        check_all();
        rstn = 1'b1;

        // Walking zero at full rate from reset.
        enable = 1'b1;
        repeat (20) cycle();

        // Walking one, step every 4 cycles.
        div = 4'd3;
        do_restart(2'd1);
        repeat (40) cycle();

        // Bounce at full rate.
        div = 4'd0;
        do_restart(2'd2);
        repeat (32) cycle();

        // LFSR through a full 8-bit period (and many 4-bit periods).
        do_restart(2'd3);
        repeat (270) cycle();

        // Pause mid-count and resume.
        div = 4'd2;
        do_restart(2'd1);
        repeat (4) cycle();
        enable = 1'b0;
        repeat (10) cycle();
        enable = 1'b1;
        repeat (12) cycle();

        // Restart on the very edge a step is due.
        div   = 4'd3;
        guard = 0;
        while (m_cnt != 3 && guard < 20) begin
            cycle();
            guard++;
        end
        check("due_step_reached", 64'(m_cnt), 64'd3);
        do_restart(2'd0);
        repeat (10) cycle();

        // Randomised mix of restarts, rate changes and pauses.
        repeat (150) begin
            case ($urandom_range(0, 3))
                0: begin
                    restart = 1'b1;
                    mode    = 2'($urandom_range(0, 3));
                end
                1: div = 4'($urandom_range(0, 3));
                2: enable = ~enable;
                default: ;
            endcase
            cycle();
            restart = 1'b0;
            repeat ($urandom_range(0, 6)) cycle();
        end

        // Asynchronous reset mid-run, away from any clock edge.
        enable = 1'b1;
        div    = 4'd0;
        do_restart(2'd2);
        repeat (5) cycle();
        #2;
        rstn = 1'b0;
        #1;
        model_reset();
        check_all();
        #1;
        rstn = 1'b1;
        repeat (20) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
